// File: rtl/ram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_if
//
// Bundles the two-requester request/response handshake and the 1R1W memory
// port of ram_port_arbiter. Clock and reset stay outside the interface.
//
// Modports:
//   slave  - the arbiter: samples requests and memory read data, drives
//            ready/response and the memory read/write controls.
//   master - the client/memory side: drives requests and memory read data,
//            observes ready/response and the memory controls.
//
// Signals:
//   req_valid[1:0], req_write[1:0]     per-requester valid and 1=write/0=read
//   req_addr0/1, req_wdata0/1          per-requester address and write data
//   req_ready[1:0]                     combinational accept
//   rsp_valid[1:0], rsp_rdata0/1       registered read response
//   mem_r_en, mem_r_addr, mem_r_data   memory read port (combinational data)
//   mem_w_en, mem_w_mask, mem_w_addr,
//   mem_w_data                         memory write port (written on clock)
// ----------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;

  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata0;
  logic [DATA_W-1:0] rsp_rdata1;

  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_r_data;
  logic              mem_w_en;
  logic              mem_w_mask;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_w_data;

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  mem_r_data,
    output req_ready, rsp_valid, rsp_rdata0, rsp_rdata1,
    output mem_r_en, mem_r_addr, mem_w_en, mem_w_mask, mem_w_addr, mem_w_data
  );

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output mem_r_data,
    input  req_ready, rsp_valid, rsp_rdata0, rsp_rdata1,
    input  mem_r_en, mem_r_addr, mem_w_en, mem_w_mask, mem_w_addr, mem_w_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//
// Two-requester arbiter in front of an external 1R1W memory with a
// combinational read port and a clocked write port. The read port and the
// write port are arbitrated independently, each with a 1-bit round-robin
// pointer, so one read and one write can be granted in the same cycle.
// Read data is captured at the accepting edge and presented one cycle later
// with a single-cycle rsp_valid pulse to the winning requester.
//
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - ram_port_arbiter_if.slave (requests, responses, memory port)
//
// Build option:
//   RAM_PORT_ARB_BYPASS_EN - when defined, a read and write granted in the
//   same cycle to the same address return the new (write) data. Otherwise the
//   old memory word is returned and no address comparator exists.
// ----------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ram_port_arbiter_if.slave    bus
);

  generate
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
      $error("ram_port_arbiter: DEPTH must equal 2**ADDR_W");
    end
  endgenerate

  // Round-robin pointers: the requester preferred when both compete.
  logic              rd_ptr;
  logic              wr_ptr;

  logic [1:0]        rd_cand;
  logic [1:0]        wr_cand;
  logic [1:0]        rd_gnt;
  logic [1:0]        wr_gnt;

  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] rd_capture;

  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata0_q;
  logic [DATA_W-1:0] rsp_rdata1_q;

  assign rd_cand = bus.req_valid & ~bus.req_write;
  assign wr_cand = bus.req_valid &  bus.req_write;

  always_comb begin
    rd_gnt = 2'b00;
    case (rd_cand)
      2'b01:   rd_gnt = 2'b01;
      2'b10:   rd_gnt = 2'b10;
      2'b11:   rd_gnt = rd_ptr ? 2'b10 : 2'b01;
      default: rd_gnt = 2'b00;
    endcase
  end

  always_comb begin
    wr_gnt = 2'b00;
    case (wr_cand)
      2'b01:   wr_gnt = 2'b01;
      2'b10:   wr_gnt = 2'b10;
      2'b11:   wr_gnt = wr_ptr ? 2'b10 : 2'b01;
      default: wr_gnt = 2'b00;
    endcase
  end

  // A requester is a candidate for only one of the two ports, so the grants
  // are disjoint per requester and can simply be ORed.
  assign bus.req_ready = rd_gnt | wr_gnt;

  // Memory read port
  assign r_en   = |rd_gnt;
  assign r_addr = rd_gnt[1] ? bus.req_addr1 : bus.req_addr0;

  // Memory write port; with no grant, requester 0's fields pass through.
  assign w_en   = |wr_gnt;
  assign w_addr = wr_gnt[1] ? bus.req_addr1  : bus.req_addr0;
  assign w_data = wr_gnt[1] ? bus.req_wdata1 : bus.req_wdata0;

  assign bus.mem_r_en   = r_en;
  assign bus.mem_r_addr = r_addr;
  assign bus.mem_w_en   = w_en;
  assign bus.mem_w_mask = w_en;
  assign bus.mem_w_addr = w_addr;
  assign bus.mem_w_data = w_data;

`ifdef RAM_PORT_ARB_BYPASS_EN
  // Forward the word being written this cycle so the read sees the new value.
  logic bypass_hit;
  assign bypass_hit = r_en & w_en & (r_addr == w_addr);
  assign rd_capture = bypass_hit ? w_data : bus.mem_r_data;
`else
  assign rd_capture = bus.mem_r_data;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata0_q <= '0;
      rsp_rdata1_q <= '0;
    end else begin
      // After a grant to i the other requester gets priority.
      if (rd_gnt[0])      rd_ptr <= 1'b1;
      else if (rd_gnt[1]) rd_ptr <= 1'b0;

      if (wr_gnt[0])      wr_ptr <= 1'b1;
      else if (wr_gnt[1]) wr_ptr <= 1'b0;

      rsp_valid_q <= rd_gnt;
      if (rd_gnt[0]) rsp_rdata0_q <= rd_capture;
      if (rd_gnt[1]) rsp_rdata1_q <= rd_capture;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata0 = rsp_rdata0_q;
  assign bus.rsp_rdata1 = rsp_rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Directed bench for ram_port_arbiter. Holds a behavioural 16x32 memory
// (combinational read, write on rising clock) behind the arbiter's memory
// port. Inputs are driven after the falling edge; ready is sampled shortly
// after driving and registered outputs shortly after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ram_port_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  ram_port_arbiter #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = 4'd0;
  logic [31:0] pre_data = 32'd0;

  assign bus.mem_r_data = mem[bus.mem_r_addr];

  always @(posedge clock) begin
    if (pre_we)            mem[pre_addr] <= pre_data;
    else if (bus.mem_w_en) mem[bus.mem_w_addr] <= bus.mem_w_data;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clock);
    #1 pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n       = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.req_valid  = 2'b11;
    bus.req_write  = 2'b00;
    bus.req_addr0  = 4'd1;
    bus.req_addr1  = 4'd2;
    bus.req_wdata0 = 32'd0;
    bus.req_wdata1 = 32'd0;
    preload(4'd1, 32'h1111_1111);
    preload(4'd2, 32'h2222_2222);
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid);
    else n_pass++;
    n_checks++;
    if (bus.rsp_rdata0 !== 32'd0 || bus.rsp_rdata1 !== 32'd0)
      $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.rsp_rdata0, bus.rsp_rdata1);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 2'b01) $display("FAIL reset_ready: got %b expected 01", bus.req_ready);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00) $display("FAIL reset_hold_rsp: got %b expected 00", bus.rsp_valid);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) $display("FAIL post_reset_ready0: got %b expected 01", bus.req_ready);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata0 !== 32'h1111_1111)
      $display("FAIL post_reset_rsp0: got %b %h expected 01 11111111", bus.rsp_valid, bus.rsp_rdata0);
    else n_pass++;
    @(negedge clock); #1;
    n_checks++;
    if (bus.req_ready !== 2'b10) $display("FAIL post_reset_ready1: got %b expected 10", bus.req_ready);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata1 !== 32'h2222_2222)
      $display("FAIL post_reset_rsp1: got %b %h expected 10 22222222", bus.rsp_valid, bus.rsp_rdata1);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 2'b00;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      bus.req_valid = 2'b11;
      bus.req_write = 2'b00;
      bus.req_addr0 = 4'd1;
      bus.req_addr1 = 4'd2;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (bus.req_ready !== exp_g) $display("FAIL contention_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_g);
      else n_pass++;
      @(posedge clock); #1;
      n_checks++;
      if (bus.rsp_valid !== exp_g) $display("FAIL contention_rsp[%0d]: got %b expected %b", k, bus.rsp_valid, exp_g);
      else n_pass++;
      n_checks++;
      if (exp_g[0] && bus.rsp_rdata0 !== 32'h1111_1111)
        $display("FAIL contention_data0[%0d]: got %h expected 11111111", k, bus.rsp_rdata0);
      else if (exp_g[1] && bus.rsp_rdata1 !== 32'h2222_2222)
        $display("FAIL contention_data1[%0d]: got %h expected 22222222", k, bus.rsp_rdata1);
      else n_pass++;
    end
    @(negedge clock);
    bus.req_valid = 2'b00;
  endtask

  task automatic test_parallel();
    do_reset();
    preload(4'd3, 32'h0000_0000);
    preload(4'd5, 32'h5555_5555);
    @(negedge clock);
    bus.req_valid  = 2'b11;
    bus.req_write  = 2'b01;
    bus.req_addr0  = 4'd3;
    bus.req_wdata0 = 32'hDEAD_BEEF;
    bus.req_addr1  = 4'd5;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b11) $display("FAIL parallel_ready: got %b expected 11", bus.req_ready);
    else n_pass++;
    n_checks++;
    if (bus.mem_w_en !== 1'b1 || bus.mem_w_mask !== 1'b1 || bus.mem_w_addr !== 4'd3 ||
        bus.mem_w_data !== 32'hDEAD_BEEF || bus.mem_r_en !== 1'b1 || bus.mem_r_addr !== 4'd5)
      $display("FAIL parallel_memport: got w%b m%b wa%h wd%h r%b ra%h expected w1 m1 wa3 wddeadbeef r1 ra5",
               bus.mem_w_en, bus.mem_w_mask, bus.mem_w_addr, bus.mem_w_data, bus.mem_r_en, bus.mem_r_addr);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata1 !== 32'h5555_5555)
      $display("FAIL parallel_rsp1: got %b %h expected 10 55555555", bus.rsp_valid, bus.rsp_rdata1);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr0 = 4'd3;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01 || bus.mem_w_en !== 1'b0)
      $display("FAIL parallel_readback_ready: got %b w%b expected 01 w0", bus.req_ready, bus.mem_w_en);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata0 !== 32'hDEAD_BEEF)
      $display("FAIL parallel_readback: got %b %h expected 01 deadbeef", bus.rsp_valid, bus.rsp_rdata0);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 2'b00;
  endtask

  task automatic test_collision();
    logic [31:0] exp_d;
`ifdef RAM_PORT_ARB_BYPASS_EN
    exp_d = 32'h1234_5678;
`else
    exp_d = 32'hAAAA_5555;
`endif
    do_reset();
    preload(4'd7, 32'hAAAA_5555);
    @(negedge clock);
    bus.req_valid  = 2'b11;
    bus.req_write  = 2'b01;
    bus.req_addr0  = 4'd7;
    bus.req_wdata0 = 32'h1234_5678;
    bus.req_addr1  = 4'd7;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b11) $display("FAIL collision_ready: got %b expected 11", bus.req_ready);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata1 !== exp_d)
      $display("FAIL collision_data: got %b %h expected 10 %h", bus.rsp_valid, bus.rsp_rdata1, exp_d);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 2'b10;
    bus.req_write = 2'b00;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata1 !== 32'h1234_5678)
      $display("FAIL collision_after: got %b %h expected 10 12345678", bus.rsp_valid, bus.rsp_rdata1);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 2'b00;
  endtask

  task automatic test_write_contention();
    do_reset();
    @(negedge clock);
    bus.req_valid  = 2'b11;
    bus.req_write  = 2'b11;
    bus.req_addr0  = 4'd12;
    bus.req_wdata0 = 32'hA0A0_A0A0;
    bus.req_addr1  = 4'd13;
    bus.req_wdata1 = 32'hB1B1_B1B1;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01 || bus.mem_w_addr !== 4'd12)
      $display("FAIL wr_contention_0: got %b %h expected 01 c", bus.req_ready, bus.mem_w_addr);
    else n_pass++;
    @(negedge clock); #1;
    n_checks++;
    if (bus.req_ready !== 2'b10 || bus.mem_w_addr !== 4'd13 || bus.mem_w_data !== 32'hB1B1_B1B1)
      $display("FAIL wr_contention_1: got %b %h %h expected 10 d b1b1b1b1", bus.req_ready, bus.mem_w_addr, bus.mem_w_data);
    else n_pass++;
    @(negedge clock);
    bus.req_write = 2'b00;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata0 !== 32'hA0A0_A0A0)
      $display("FAIL wr_contention_rd0: got %b %h expected 01 a0a0a0a0", bus.rsp_valid, bus.rsp_rdata0);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata1 !== 32'hB1B1_B1B1)
      $display("FAIL wr_contention_rd1: got %b %h expected 10 b1b1b1b1", bus.rsp_valid, bus.rsp_rdata1);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 2'b00;
  endtask

  task automatic test_single();
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) preload(4'(8 + i), 32'hC0DE_0008 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.req_valid = 2'b10;
      bus.req_write = 2'b00;
      bus.req_addr1 = 4'(8 + i);
      exp_d = 32'hC0DE_0008 + 32'(i);
      #1;
      n_checks++;
      if (bus.req_ready !== 2'b10 || bus.mem_r_addr !== 4'(8 + i))
        $display("FAIL single_ready[%0d]: got %b %h expected 10 %h", i, bus.req_ready, bus.mem_r_addr, 4'(8 + i));
      else n_pass++;
      @(posedge clock); #1;
      n_checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata1 !== exp_d || dut.rd_ptr !== 1'b0)
        $display("FAIL single_rsp[%0d]: got %b %h ptr%b expected 10 %h ptr0", i, bus.rsp_valid, bus.rsp_rdata1, dut.rd_ptr, exp_d);
      else n_pass++;
    end
    @(negedge clock);
    bus.req_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00 || bus.mem_r_en !== 1'b0 || bus.mem_w_en !== 1'b0)
      $display("FAIL idle_ready: got %b r%b w%b expected 00 r0 w0", bus.req_ready, bus.mem_r_en, bus.mem_w_en);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00) $display("FAIL idle_rsp: got %b expected 00", bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr0 = 4'd1;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || dut.rd_ptr !== 1'b1)
      $display("FAIL mid_first: got %b ptr%b expected 01 ptr1", bus.rsp_valid, dut.rd_ptr);
    else n_pass++;
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) $display("FAIL mid_ready: got %b expected 01", bus.req_ready);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00) $display("FAIL mid_async_clear: got %b expected 00", bus.rsp_valid);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || dut.rd_ptr !== 1'b0 || dut.wr_ptr !== 1'b0)
      $display("FAIL mid_dropped: got %b ptr%b/%b expected 00 ptr0/0", bus.rsp_valid, dut.rd_ptr, dut.wr_ptr);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00) $display("FAIL mid_after_release: got %b expected 00", bus.rsp_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_parallel();
    test_collision();
    test_write_contention();
    test_single();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
